// File: rtl/ddsm_mod_ctrl_if.sv
// Configuration, control and modulator-facing signal bundle for the MASH
// sequencer; slave is the sequencer side, master is the driving side.
interface ddsm_mod_ctrl_if #(
    parameter int P_DATA_WIDTH = 8
);
    logic                    i_cfg_valid;
    logic                    o_cfg_ready;
    logic [P_DATA_WIDTH-1:0] i_cfg_frac;
    logic [P_DATA_WIDTH-1:0] i_cfg_seed;
    logic [1:0]              i_cfg_order;
    logic                    i_start;
    logic                    i_stop;
    logic [P_DATA_WIDTH-1:0] o_efm_data;
    logic [P_DATA_WIDTH-1:0] o_seed;
    logic                    o_mod_rst_n;
    logic [2:0]              o_stage_en;
    logic                    o_out_valid;
    logic                    o_busy;

    modport slave (
        input  i_cfg_valid, i_cfg_frac, i_cfg_seed, i_cfg_order, i_start, i_stop,
        output o_cfg_ready, o_efm_data, o_seed, o_mod_rst_n, o_stage_en,
               o_out_valid, o_busy
    );

    modport master (
        output i_cfg_valid, i_cfg_frac, i_cfg_seed, i_cfg_order, i_start, i_stop,
        input  o_cfg_ready, o_efm_data, o_seed, o_mod_rst_n, o_stage_en,
               o_out_valid, o_busy
    );
endinterface

// File: rtl/ddsm_mod_ctrl.sv
// Sequencer for a MASH chain of up to three EFM stages: holds the stages in
// reset, seeds and releases them, times warm-up, and applies frac updates live.
module ddsm_mod_ctrl #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_WARMUP     = 8,
    parameter int P_LOAD_CYC   = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    ddsm_mod_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LOAD   = 8'(P_LOAD_CYC);
    localparam logic [7:0] CNT_WARMUP = 8'(P_WARMUP);

    function automatic logic [2:0] stage_mask(input logic [1:0] order);
        logic [2:0] mask;
        case (order)
            2'd2:    mask = 3'b011;
            2'd3:    mask = 3'b111;
            default: mask = 3'b001;
        endcase
        return mask;
    endfunction

    state_t                  state_r, next_state_s;
    logic [7:0]              cnt_r, cnt_next_s;
    logic [P_DATA_WIDTH-1:0] shadow_seed_r;
    logic [1:0]              shadow_order_r;
    logic [1:0]              run_order_r;
    logic [P_DATA_WIDTH-1:0] efm_data_r, seed_r;
    logic                    cfg_ready_r, mod_rst_n_r, out_valid_r, busy_r;
    logic [2:0]              stage_en_r;

    logic                    accept_s, start_s, enabled_s;
    logic                    cfg_ready_next_s, busy_next_s, out_valid_next_s;
    logic [2:0]              stage_en_next_s;

    // Next state and down-counter for the LOAD and WARMUP phases.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = 8'd0;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_start && !bus.i_stop) begin
                    next_state_s = ST_LOAD;
                    cnt_next_s   = CNT_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (bus.i_stop) begin
                    next_state_s = ST_IDLE;
                end else if (cnt_r <= 8'd1) begin
                    next_state_s = ST_WARMUP;
                    cnt_next_s   = CNT_WARMUP;
                end else begin
                    cnt_next_s   = cnt_r - 8'd1;
                end
            end
            ST_WARMUP: begin
                if (bus.i_stop) begin
                    next_state_s = ST_IDLE;
                end else if (cnt_r <= 8'd1) begin
                    next_state_s = ST_RUN;
                end else begin
                    cnt_next_s   = cnt_r - 8'd1;
                end
            end
            ST_RUN: begin
                if (bus.i_stop) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output next-values: stage controls follow the current phase one edge
    // later, except that a stop drops them on the stop edge itself.
    always_comb begin
        accept_s         = bus.i_cfg_valid && cfg_ready_r;
        start_s          = (state_r == ST_IDLE) && (next_state_s == ST_LOAD);
        enabled_s        = ((state_r == ST_WARMUP) || (state_r == ST_RUN)) && !bus.i_stop;
        out_valid_next_s = (state_r == ST_RUN) && !bus.i_stop;
        cfg_ready_next_s = (next_state_s == ST_IDLE) || (next_state_s == ST_RUN);
        busy_next_s      = (next_state_s != ST_IDLE);
        if (enabled_s) begin
            stage_en_next_s = stage_mask(run_order_r);
        end else begin
            stage_en_next_s = 3'b000;
        end
    end

    // FSM state and phase counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Shadow configuration; the order in use is frozen at each start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow_seed_r  <= '0;
            shadow_order_r <= 2'd1;
            run_order_r    <= 2'd1;
        end else begin
            if (accept_s) begin
                shadow_seed_r  <= bus.i_cfg_seed;
                shadow_order_r <= bus.i_cfg_order;
            end
            if (start_s) begin
                run_order_r <= accept_s ? bus.i_cfg_order : shadow_order_r;
            end
        end
    end

    // Datapath outputs: frac applies whenever accepted, seed only from IDLE
    // or when the stages are being loaded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            efm_data_r <= '0;
            seed_r     <= '0;
        end else begin
            if (accept_s) begin
                efm_data_r <= bus.i_cfg_frac;
            end
            if (accept_s && (state_r == ST_IDLE)) begin
                seed_r <= bus.i_cfg_seed;
            end else if (state_r == ST_LOAD) begin
                seed_r <= shadow_seed_r;
            end
        end
    end

    // Registered control outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cfg_ready_r <= 1'b0;
            mod_rst_n_r <= 1'b0;
            stage_en_r  <= 3'b000;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            cfg_ready_r <= cfg_ready_next_s;
            mod_rst_n_r <= enabled_s;
            stage_en_r  <= stage_en_next_s;
            out_valid_r <= out_valid_next_s;
            busy_r      <= busy_next_s;
        end
    end

    assign bus.o_cfg_ready = cfg_ready_r;
    assign bus.o_efm_data  = efm_data_r;
    assign bus.o_seed      = seed_r;
    assign bus.o_mod_rst_n = mod_rst_n_r;
    assign bus.o_stage_en  = stage_en_r;
    assign bus.o_out_valid = out_valid_r;
    assign bus.o_busy      = busy_r;
endmodule

// File: tb/tb_ddsm_mod_ctrl.sv
// Scoreboard bench for ddsm_mod_ctrl: expected output snapshots are queued as
// stimulus is driven and compared one per edge, 1 time unit after the edge.
module tb_ddsm_mod_ctrl;
    localparam int W  = 8;
    localparam int LC = 2;
    localparam int WU = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Snapshot layout: {efm, seed, mod_rst_n, stage_en, out_valid, busy, cfg_ready}
    logic [22:0] sb_q[$];
    logic [22:0] obs;
    logic [22:0] e;

    ddsm_mod_ctrl_if #(.P_DATA_WIDTH(W)) bus ();

    ddsm_mod_ctrl #(.P_DATA_WIDTH(W), .P_WARMUP(WU), .P_LOAD_CYC(LC)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    assign obs = {bus.o_efm_data, bus.o_seed, bus.o_mod_rst_n, bus.o_stage_en,
                  bus.o_out_valid, bus.o_busy, bus.o_cfg_ready};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [22:0] idle_v(logic [7:0] efm, logic [7:0] seed, logic rdy);
        return {efm, seed, 1'b0, 3'b000, 1'b0, 1'b0, rdy};
    endfunction

    // Expected snapshot k edges after a start sampled in IDLE.
    function automatic logic [22:0] prof(int k, logic [2:0] mask, logic [7:0] efm,
                                         logic [7:0] seed0, logic [7:0] seed1);
        logic up;
        up = (k >= LC + 1);
        return {efm, (k == 0) ? seed0 : seed1, up, up ? mask : 3'b000,
                (k >= LC + WU + 1), 1'b1, (k >= LC + WU)};
    endfunction

    task automatic test_reset();
        bus.i_cfg_valid = 1'b0; bus.i_cfg_frac = 8'h00; bus.i_cfg_seed = 8'h00;
        bus.i_cfg_order = 2'd0; bus.i_start = 1'b0; bus.i_stop = 1'b0;
        rst_n = 1'b0;
        sb_q.push_back(idle_v(8'h00, 8'h00, 1'b0));
        #12;
        e = sb_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_hold got %h expected %h", obs, e); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_q.push_back(idle_v(8'h00, 8'h00, 1'b1));
        tick();
        e = sb_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_release got %h expected %h", obs, e); end
    endtask

    task automatic test_start();
        bus.i_cfg_valid = 1'b1; bus.i_cfg_frac = 8'h40; bus.i_cfg_seed = 8'h01; bus.i_cfg_order = 2'd3;
        sb_q.push_back(idle_v(8'h40, 8'h01, 1'b1));
        tick();
        bus.i_cfg_valid = 1'b0;
        e = sb_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL cfg_idle got %h expected %h", obs, e); end
        bus.i_start = 1'b1;
        for (int k = 0; k <= 12; k++) sb_q.push_back(prof(k, 3'b111, 8'h40, 8'h01, 8'h01));
        for (int k = 0; k <= 12; k++) begin
            tick();
            if (k == 0) bus.i_start = 1'b0;
            e = sb_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL start_seq k=%0d got %h expected %h", k, obs, e); end
        end
    endtask

    task automatic test_run_update();
        bus.i_cfg_valid = 1'b1; bus.i_cfg_frac = 8'hC0; bus.i_cfg_seed = 8'h55; bus.i_cfg_order = 2'd1;
        sb_q.push_back(prof(20, 3'b111, 8'hC0, 8'h01, 8'h01));
        sb_q.push_back(prof(20, 3'b111, 8'hC0, 8'h01, 8'h01));
        for (int k = 0; k < 2; k++) begin
            tick();
            bus.i_cfg_valid = 1'b0;
            e = sb_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL run_update k=%0d got %h expected %h", k, obs, e); end
        end
        bus.i_stop = 1'b1;
        sb_q.push_back(idle_v(8'hC0, 8'h01, 1'b1));
        tick();
        bus.i_stop = 1'b0;
        e = sb_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL stop_run got %h expected %h", obs, e); end
        bus.i_start = 1'b1;
        for (int k = 0; k <= 11; k++) sb_q.push_back(prof(k, 3'b001, 8'hC0, 8'h01, 8'h55));
        for (int k = 0; k <= 11; k++) begin
            tick();
            if (k == 0) bus.i_start = 1'b0;
            e = sb_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL restart_seq k=%0d got %h expected %h", k, obs, e); end
        end
        bus.i_stop = 1'b1;
        sb_q.push_back(idle_v(8'hC0, 8'h55, 1'b1));
        tick();
        bus.i_stop = 1'b0;
        e = sb_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL stop_restart got %h expected %h", obs, e); end
    endtask

    task automatic test_stop_warmup();
        bus.i_start = 1'b1;
        for (int k = 0; k <= 16; k++)
            sb_q.push_back((k <= 4) ? prof(k, 3'b001, 8'hC0, 8'h55, 8'h55) : idle_v(8'hC0, 8'h55, 1'b1));
        for (int k = 0; k <= 16; k++) begin
            tick();
            if (k == 0) bus.i_start = 1'b0;
            if (k == 4) bus.i_stop = 1'b1;
            if (k == 5) bus.i_stop = 1'b0;
            e = sb_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL stop_warmup k=%0d got %h expected %h", k, obs, e); end
        end
    endtask

    task automatic test_start_stop_conflict();
        bus.i_start = 1'b1; bus.i_stop = 1'b1;
        for (int k = 0; k < 3; k++) sb_q.push_back(idle_v(8'hC0, 8'h55, 1'b1));
        for (int k = 0; k < 3; k++) begin
            tick();
            e = sb_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL start_stop k=%0d got %h expected %h", k, obs, e); end
        end
        bus.i_stop = 1'b0;
        bus.i_cfg_valid = 1'b1; bus.i_cfg_frac = 8'h12; bus.i_cfg_seed = 8'h34; bus.i_cfg_order = 2'd0;
        for (int k = 0; k <= 11; k++) sb_q.push_back(prof(k, 3'b001, 8'h12, 8'h34, 8'h34));
        for (int k = 0; k <= 11; k++) begin
            tick();
            if (k == 0) begin bus.i_start = 1'b0; bus.i_cfg_valid = 1'b0; end
            e = sb_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL order0_start k=%0d got %h expected %h", k, obs, e); end
        end
    endtask

    task automatic test_cfg_blocked();
        bus.i_stop = 1'b1;
        sb_q.push_back(idle_v(8'h12, 8'h34, 1'b1));
        tick();
        bus.i_stop = 1'b0;
        e = sb_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL stop_before_block got %h expected %h", obs, e); end
        bus.i_start = 1'b1;
        bus.i_cfg_frac = 8'hAA; bus.i_cfg_seed = 8'h77; bus.i_cfg_order = 2'd2;
        for (int k = 0; k <= 13; k++) begin
            e = prof(k, 3'b001, 8'h12, 8'h34, 8'h34);
            if (k >= LC + WU + 1) e[22:15] = 8'hAA;
            sb_q.push_back(e);
        end
        for (int k = 0; k <= 13; k++) begin
            tick();
            if (k == 0) begin bus.i_start = 1'b0; bus.i_cfg_valid = 1'b1; end
            if (k == LC + WU + 1) bus.i_cfg_valid = 1'b0;
            e = sb_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL cfg_blocked k=%0d got %h expected %h", k, obs, e); end
        end
    endtask

    task automatic test_async_reset();
        #3;
        rst_n = 1'b0;
        sb_q.push_back(23'd0);
        sb_q.push_back(23'd0);
        #1;
        e = sb_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL async_reset got %h expected %h", obs, e); end
        tick();
        e = sb_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL reset_held got %h expected %h", obs, e); end
        rst_n = 1'b1;
        sb_q.push_back(idle_v(8'h00, 8'h00, 1'b1));
        tick();
        e = sb_q.pop_front(); checks++;
        if (obs !== e) begin errors++; $display("FAIL post_reset_idle got %h expected %h", obs, e); end
        bus.i_start = 1'b1;
        for (int k = 0; k <= 11; k++) sb_q.push_back(prof(k, 3'b001, 8'h00, 8'h00, 8'h00));
        for (int k = 0; k <= 11; k++) begin
            tick();
            if (k == 0) bus.i_start = 1'b0;
            e = sb_q.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL post_reset_start k=%0d got %h expected %h", k, obs, e); end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_run_update();
        test_stop_warmup();
        test_start_stop_conflict();
        test_cfg_blocked();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
